// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the CPU port, the loader/debug port, the memory and the arbiter.
interface mem_port_arbiter_if;
  // CPU-side requester
  logic        c_req;
  logic        c_we;
  logic [31:0] c_addr;
  logic [31:0] c_wdata;
  logic [31:0] c_rdata;
  logic        c_ack;

  // Loader/debug-side requester
  logic        d_req;
  logic        d_we;
  logic        d_lock;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;

  // Single-ported memory, combinational read data
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;

  // Arbiter view
  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    output c_rdata, c_ack,
    input  d_req, d_we, d_lock, d_addr, d_wdata,
    output d_rdata, d_ack,
    output mem_addr, mem_wdata, mem_read, mem_write,
    input  mem_rdata
  );

  // Requesters and memory view
  modport master (
    output c_req, c_we, c_addr, c_wdata,
    input  c_rdata, c_ack,
    output d_req, d_we, d_lock, d_addr, d_wdata,
    input  d_rdata, d_ack,
    input  mem_addr, mem_wdata, mem_read, mem_write,
    output mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for one memory port: CPU (C) and loader/debug (D).
// Each access is one SERVE cycle driving the memory followed by one ACK cycle;
// ties are round-robin, and D may lock the port for up to MAX_LOCK grants.
module mem_port_arbiter #(
  parameter int MAX_LOCK = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  mem_port_arbiter_if.slave     bus,
  output logic                  cpu_stall,
  output logic [1:0]            owner
);

  localparam int CNT_W = $clog2(MAX_LOCK + 1);

  typedef enum logic [2:0] {
    IDLE,
    SERVE_C,
    SERVE_D,
    ACK_C,
    ACK_D
  } state_t;

  state_t           state;
  logic             last_grant_d;
  logic [CNT_W-1:0] lock_cnt;
  logic             arb_slot;
  logic             lock_active;
  logic             grant_c;
  logic             grant_d;

  // Grant decision for the coming edge; only meaningful in IDLE and the ACK states.
  always_comb begin
    arb_slot    = (state == IDLE) || (state == ACK_C) || (state == ACK_D);
    lock_active = last_grant_d && bus.d_lock && (lock_cnt < CNT_W'(MAX_LOCK));
    grant_c     = 1'b0;
    grant_d     = 1'b0;
    if (arb_slot) begin
      if (bus.c_req && bus.d_req) begin
        if (lock_active || !last_grant_d) begin
          grant_d = 1'b1;
        end else begin
          grant_c = 1'b1;
        end
      end else if (bus.c_req) begin
        grant_c = 1'b1;
      end else if (bus.d_req) begin
        grant_d = 1'b1;
      end
    end
  end

  assign cpu_stall = bus.c_req & ~bus.c_ack;

  // Main FSM with registered memory strobes, acks, read data and owner.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      last_grant_d  <= 1'b1;
      lock_cnt      <= '0;
      owner         <= 2'b00;
      bus.c_ack     <= 1'b0;
      bus.d_ack     <= 1'b0;
      bus.c_rdata   <= '0;
      bus.d_rdata   <= '0;
      bus.mem_read  <= 1'b0;
      bus.mem_write <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      bus.c_ack     <= 1'b0;
      bus.d_ack     <= 1'b0;
      bus.mem_read  <= 1'b0;
      bus.mem_write <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;

      if (!bus.d_lock || grant_c) begin
        lock_cnt <= '0;
      end else if (grant_d && bus.c_req && (lock_cnt < CNT_W'(MAX_LOCK))) begin
        lock_cnt <= lock_cnt + CNT_W'(1);
      end

      case (state)
        SERVE_C: begin
          state     <= ACK_C;
          bus.c_ack <= 1'b1;
          if (bus.mem_read) begin
            bus.c_rdata <= bus.mem_rdata;
          end
        end
        SERVE_D: begin
          state     <= ACK_D;
          bus.d_ack <= 1'b1;
          if (bus.mem_read) begin
            bus.d_rdata <= bus.mem_rdata;
          end
        end
        default: begin
          if (grant_c) begin
            state         <= SERVE_C;
            last_grant_d  <= 1'b0;
            owner         <= 2'b01;
            bus.mem_read  <= ~bus.c_we;
            bus.mem_write <= bus.c_we;
            bus.mem_addr  <= bus.c_addr;
            bus.mem_wdata <= bus.c_wdata;
          end else if (grant_d) begin
            state         <= SERVE_D;
            last_grant_d  <= 1'b1;
            owner         <= 2'b10;
            bus.mem_read  <= ~bus.d_we;
            bus.mem_write <= bus.d_we;
            bus.mem_addr  <= bus.d_addr;
            bus.mem_wdata <= bus.d_wdata;
          end else begin
            state <= IDLE;
            owner <= 2'b00;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a table of single accesses plus
// hand-written tie, lock and reset-abort sequences.
module tb_mem_port_arbiter;

  localparam int MAX_LOCK = 4;

  logic       clk;
  logic       reset;
  logic       cpu_stall;
  logic [1:0] owner;
  int         tests_run;
  int         tests_failed;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.MAX_LOCK(MAX_LOCK)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .cpu_stall (cpu_stall),
    .owner     (owner)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case anything wedges.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Field order: c_req c_we c_addr c_wdata d_req d_we d_addr d_wdata mem_rdata
  //              exp_owner exp_read exp_write exp_addr exp_wdata exp_c_rdata exp_d_rdata
  typedef struct {
    logic        c_req;
    logic        c_we;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] mem_rdata;
    logic [1:0]  exp_owner;
    logic        exp_read;
    logic        exp_write;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [31:0] exp_c_rdata;
    logic [31:0] exp_d_rdata;
  } vec_t;

  vec_t vecs[5];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic clearInputs();
    bus.c_req     = 1'b0;
    bus.c_we      = 1'b0;
    bus.c_addr    = '0;
    bus.c_wdata   = '0;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_lock    = 1'b0;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    bus.mem_rdata = '0;
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.c_req     = v.c_req;
    bus.c_we      = v.c_we;
    bus.c_addr    = v.c_addr;
    bus.c_wdata   = v.c_wdata;
    bus.d_req     = v.d_req;
    bus.d_we      = v.d_we;
    bus.d_addr    = v.d_addr;
    bus.d_wdata   = v.d_wdata;
    bus.mem_rdata = v.mem_rdata;
  endtask

  task automatic resetDut();
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b0;
    clearInputs();

    vecs[0] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h1234_ABCD,
                2'b01, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 32'h1234_ABCD, 32'h0};
    vecs[1] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 32'h5555_5555,
                2'b10, 1'b0, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 32'h1234_ABCD, 32'h0};
    vecs[2] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0000_0200, 32'h7777_7777, 32'hCAFE_F00D,
                2'b10, 1'b1, 1'b0, 32'h0000_0200, 32'h7777_7777, 32'h1234_ABCD, 32'hCAFE_F00D};
    vecs[3] = '{1'b1, 1'b1, 32'h0000_0044, 32'h0BAD_C0DE, 1'b0, 1'b0, 32'h0, 32'h0, 32'h1111_1111,
                2'b01, 1'b0, 1'b1, 32'h0000_0044, 32'h0BAD_C0DE, 32'h1234_ABCD, 32'hCAFE_F00D};
    vecs[4] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'hFFFF_FFFF,
                2'b01, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFFF, 32'hCAFE_F00D};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_owner", 32'(owner), 32'h0);
    checkOutput("rst_mem_read", 32'(bus.mem_read), 32'h0);
    checkOutput("rst_mem_write", 32'(bus.mem_write), 32'h0);
    checkOutput("rst_mem_addr", bus.mem_addr, 32'h0);
    checkOutput("rst_c_ack", 32'(bus.c_ack), 32'h0);
    checkOutput("rst_d_ack", 32'(bus.d_ack), 32'h0);
    checkOutput("rst_c_rdata", bus.c_rdata, 32'h0);
    checkOutput("rst_d_rdata", bus.d_rdata, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Single accesses from the table
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      @(posedge clk);
      #1;
      checkOutput($sformatf("v%0d_serve_owner", i), 32'(owner), 32'(vecs[i].exp_owner));
      checkOutput($sformatf("v%0d_mem_read", i), 32'(bus.mem_read), 32'(vecs[i].exp_read));
      checkOutput($sformatf("v%0d_mem_write", i), 32'(bus.mem_write), 32'(vecs[i].exp_write));
      checkOutput($sformatf("v%0d_mem_addr", i), bus.mem_addr, vecs[i].exp_addr);
      checkOutput($sformatf("v%0d_mem_wdata", i), bus.mem_wdata, vecs[i].exp_wdata);
      checkOutput($sformatf("v%0d_serve_acks", i), {30'd0, bus.c_ack, bus.d_ack}, 32'h0);
      checkOutput($sformatf("v%0d_serve_stall", i), 32'(cpu_stall), 32'(vecs[i].c_req));
      @(posedge clk);
      #1;
      checkOutput($sformatf("v%0d_ack", i), {30'd0, bus.c_ack, bus.d_ack},
                  {30'd0, vecs[i].c_req, vecs[i].d_req});
      checkOutput($sformatf("v%0d_c_rdata", i), bus.c_rdata, vecs[i].exp_c_rdata);
      checkOutput($sformatf("v%0d_d_rdata", i), bus.d_rdata, vecs[i].exp_d_rdata);
      checkOutput($sformatf("v%0d_ack_strobes", i), {30'd0, bus.mem_read, bus.mem_write}, 32'h0);
      checkOutput($sformatf("v%0d_ack_stall", i), 32'(cpu_stall), 32'h0);
      checkOutput($sformatf("v%0d_ack_owner", i), 32'(owner), 32'(vecs[i].exp_owner));
      clearInputs();
      @(posedge clk);
      #1;
      checkOutput($sformatf("v%0d_idle_owner", i), 32'(owner), 32'h0);
    end

    // Tie after reset: C, D, C, D with 2-cycle period each
    resetDut();
    bus.c_req = 1'b1;
    bus.d_req = 1'b1;
    for (int k = 0; k < 8; k++) begin
      logic [1:0] exp_own;
      logic       exp_cack;
      logic       exp_dack;
      exp_own  = ((k / 2) % 2 == 0) ? 2'b01 : 2'b10;
      exp_cack = (k == 1) || (k == 5);
      exp_dack = (k == 3) || (k == 7);
      @(posedge clk);
      #1;
      checkOutput($sformatf("tie%0d_owner", k), 32'(owner), 32'(exp_own));
      checkOutput($sformatf("tie%0d_c_ack", k), 32'(bus.c_ack), 32'(exp_cack));
      checkOutput($sformatf("tie%0d_d_ack", k), 32'(bus.d_ack), 32'(exp_dack));
      checkOutput($sformatf("tie%0d_stall", k), 32'(cpu_stall), 32'(!exp_cack));
    end
    clearInputs();
    @(posedge clk);

    // Lock: one unlocked D grant, then 4 locked D grants, then C
    resetDut();
    bus.d_req = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("lock_first_owner", 32'(owner), 32'h2);
    @(posedge clk);
    #1;
    checkOutput("lock_first_d_ack", 32'(bus.d_ack), 32'h1);
    bus.c_req  = 1'b1;
    bus.d_lock = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("lock%0d_owner", k), 32'(owner), (k < 4) ? 32'h2 : 32'h1);
      checkOutput($sformatf("lock%0d_cnt", k), 32'(dut.lock_cnt), (k < 4) ? 32'(k + 1) : 32'h0);
      @(posedge clk);
      #1;
      checkOutput($sformatf("lock%0d_ack", k), {30'd0, bus.c_ack, bus.d_ack},
                  (k < 4) ? 32'h1 : 32'h2);
    end
    clearInputs();
    @(posedge clk);

    // Reset mid-write aborts the access, then C wins the next tie
    @(negedge clk);
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'h0000_0300;
    bus.d_wdata = 32'hA5A5_A5A5;
    @(posedge clk);
    #1;
    checkOutput("abort_pre_write", 32'(bus.mem_write), 32'h1);
    #2 reset = 1'b0;
    #1;
    checkOutput("abort_mem_write", 32'(bus.mem_write), 32'h0);
    checkOutput("abort_mem_addr", bus.mem_addr, 32'h0);
    checkOutput("abort_owner", 32'(owner), 32'h0);
    @(posedge clk);
    #1;
    checkOutput("abort_no_d_ack", 32'(bus.d_ack), 32'h0);
    bus.d_we  = 1'b0;
    bus.c_req = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("abort_tie_owner", 32'(owner), 32'h1);
    @(posedge clk);
    #1;
    checkOutput("abort_tie_c_ack", {30'd0, bus.c_ack, bus.d_ack}, 32'h2);
    clearInputs();
    @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter MAX_LOCK, default 16, giving the maximum consecutive locked D grants while c_req is pending.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous and active-low.
REQ-004 SHALL have CPU-side ports c_req, c_we (input, 1); c_addr, c_wdata (input, 32); c_rdata (output, 32); c_ack (output, 1).
REQ-005 SHALL have loader/debug-side ports d_req, d_we, d_lock (input, 1); d_addr, d_wdata (input, 32); d_rdata (output, 32); d_ack (output, 1).
REQ-006 SHALL have memory-side ports mem_addr, mem_wdata (output, 32); mem_read, mem_write (output, 1); mem_rdata (input, 32, combinational read data).
REQ-007 SHALL have status ports cpu_stall (output, 1) and owner (output, 2: 00 none, 01 C, 10 D).

Function
REQ-008 SHALL implement FSM states IDLE, SERVE_C, SERVE_D, ACK_C, ACK_D.
REQ-009 SHALL arbitrate only in IDLE, ACK_C and ACK_D; a req high at the rising edge in those states starts a grant.
REQ-010 SHALL move to SERVE_C or SERVE_D at that edge; with no req it goes to/stays in IDLE.
REQ-011 SHALL hold SERVE_x for exactly one cycle, then move to ACK_x unconditionally.
REQ-012 In SERVE_x, SHALL drive mem_addr/mem_wdata from x_addr/x_wdata, mem_read=~x_we and mem_write=x_we.
REQ-013 Outside SERVE_x, SHALL drive mem_read=0, mem_write=0, mem_addr=0 and mem_wdata=0.
REQ-014 SHALL capture mem_rdata into x_rdata at the SERVE_x->ACK_x edge on reads only; x_rdata holds its value otherwise.
REQ-015 SHALL assert x_ack for exactly the one ACK_x cycle, giving a fixed latency of req-sampled edge +2 cycles to ack high.
REQ-016 Requesters SHALL hold req/we/addr/wdata stable until ack; a req still high during the ack cycle is a new request, allowing back-to-back accesses with a 2-cycle period.
REQ-017 When only one req is high, SHALL grant that requester.
REQ-018 When both reqs are high and no lock is in force, SHALL grant round-robin: the requester not granted most recently wins.
REQ-019 Lock: if the previous grant was D, d_lock=1 and lock_cnt<MAX_LOCK, SHALL grant D even when c_req=1.
REQ-020 SHALL increment lock_cnt on each D grant made while c_req=1 and d_lock=1, saturating at MAX_LOCK.
REQ-021 SHALL clear lock_cnt on any C grant or whenever d_lock=0.
REQ-022 At lock_cnt==MAX_LOCK with c_req=1, SHALL grant C next (starvation bound).
REQ-023 SHALL drive cpu_stall = c_req & ~c_ack combinationally.
REQ-024 SHALL drive owner = 01 in SERVE_C/ACK_C, 10 in SERVE_D/ACK_D, and 00 in IDLE.
REQ-025 SHALL accept d_lock only while D holds the most recent grant; otherwise d_lock is ignored.
REQ-026 SHALL never assert mem_read and mem_write in the same cycle, and never grant both requesters in one cycle.

Reset
REQ-027 While reset=0, SHALL asynchronously force state=IDLE, last_grant=D (so C wins the first tie), lock_cnt=0, c_ack=d_ack=0, c_rdata=d_rdata=0, mem_read=mem_write=0, mem_addr=mem_wdata=0 and owner=00.
REQ-028 Reset asserted during SERVE_x SHALL abort the access with no ack issued; mem_write SHALL fall immediately, without waiting for a clock edge.
REQ-029 After reset deasserts, the first arbitration SHALL occur at the first rising edge with reset=1.

Verification
REQ-030 C read alone: c_req=1, c_we=0, c_addr=0x40, mem_rdata=0x1234ABCD -> mem_read=1 one cycle, then c_ack=1 one cycle with c_rdata=0x1234ABCD, and cpu_stall high for 2 cycles.
REQ-031 D write alone: d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF -> one cycle with mem_write=1, mem_addr=0x100 and mem_wdata=0xDEADBEEF, then d_ack=1, with d_rdata unchanged.
REQ-032 Tie after reset: c_req and d_req both held high -> grant sequence C, D, C, D, with c_ack and d_ack alternating every 2 cycles.
REQ-033 Lock with MAX_LOCK=4: D granted, then d_lock=1 and both reqs held high -> 4 further D grants, then a C grant, and lock_cnt back to 0.
REQ-034 Reset mid-write: reset=0 asynchronously mid-cycle during SERVE_D with d_we=1 -> mem_write falls immediately, no d_ack, state IDLE, and after release C wins the next tie.
